// File: rtl/clock_enable_scheduler_if.sv
// Handshake and clock-output bundle between a divisor/run controller and
// the clock enable scheduler.
interface clock_enable_scheduler_if #(
  parameter int unsigned CNT_W = 8
);
  logic             run_enable;
  logic             div_req;
  logic [CNT_W-1:0] div_value;
  logic             div_ack;
  logic             div_err;
  logic             busy;
  logic             clock_out;
  logic             tick;
  logic [1:0]       state;

  modport master (
    output run_enable, div_req, div_value,
    input  div_ack, div_err, busy, clock_out, tick, state
  );

  modport slave (
    input  run_enable, div_req, div_value,
    output div_ack, div_err, busy, clock_out, tick, state
  );
endinterface

// File: rtl/clock_enable_scheduler.sv
// Divides the master clock by 2*HP with 50% duty. Stop requests and divisor
// changes only take effect on a 1->0 boundary, so no phase is ever cut short.
module clock_enable_scheduler #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RESET_HP = 2
) (
  input logic                     master_clock_i,
  input logic                     reset_i,
  clock_enable_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    STOPPING = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_HP_C = CNT_W'(RESET_HP);

  state_e           state_q;
  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] pend_hp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_q;
  logic             clock_out_q;
  logic             tick_q;
  logic             ack_q;
  logic             err_q;
  logic             clock_out_d;
  logic             tick_d;
  logic             wrap_s;
  logic             boundary_s;
  logic             req_ok_s;
  logic             accept_s;
  logic             reject_s;
  logic             apply_s;

  // Half-period counter step and divisor request qualification
  always_comb begin
    wrap_s     = (cnt_q == (hp_q - ONE_C));
    boundary_s = wrap_s && clock_out_q;
    req_ok_s   = bus.div_req && !pend_q && !ack_q && !err_q;
    accept_s   = req_ok_s && (bus.div_value != ZERO_C);
    reject_s   = req_ok_s && (bus.div_value == ZERO_C);
    apply_s    = pend_q && ((state_q == IDLE) || boundary_s);
    if (wrap_s) begin
      cnt_d       = ZERO_C;
      clock_out_d = ~clock_out_q;
      tick_d      = ~clock_out_q;
    end else begin
      cnt_d       = cnt_q + ONE_C;
      clock_out_d = clock_out_q;
      tick_d      = 1'b0;
    end
  end

  // Scheduler FSM, divisor handshake and all registered outputs
  always_ff @(posedge master_clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      hp_q        <= RESET_HP_C;
      pend_hp_q   <= ZERO_C;
      pend_q      <= 1'b0;
      cnt_q       <= ZERO_C;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ack_q <= accept_s;
      err_q <= reject_s;
      if (accept_s) begin
        pend_hp_q <= bus.div_value;
        pend_q    <= 1'b1;
      end else if (apply_s) begin
        hp_q   <= pend_hp_q;
        pend_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          cnt_q       <= ZERO_C;
          clock_out_q <= 1'b0;
          tick_q      <= 1'b0;
          state_q     <= bus.run_enable ? RUN : IDLE;
        end
        RUN: begin
          // Stop at once if the low phase has not started counting, or on a boundary
          if (!bus.run_enable && ((!clock_out_q && (cnt_q == ZERO_C)) || boundary_s)) begin
            state_q     <= IDLE;
            cnt_q       <= ZERO_C;
            clock_out_q <= 1'b0;
            tick_q      <= 1'b0;
          end else begin
            state_q     <= bus.run_enable ? RUN : STOPPING;
            cnt_q       <= cnt_d;
            clock_out_q <= clock_out_d;
            tick_q      <= tick_d;
          end
        end
        STOPPING: begin
          state_q     <= boundary_s ? IDLE : STOPPING;
          cnt_q       <= cnt_d;
          clock_out_q <= clock_out_d;
          tick_q      <= tick_d;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= ZERO_C;
          clock_out_q <= 1'b0;
          tick_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.div_ack   = ack_q;
  assign bus.div_err   = err_q;
  assign bus.busy      = pend_q;
  assign bus.clock_out = clock_out_q;
  assign bus.tick      = tick_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Bench for clock_enable_scheduler: fixed vector table, directed multi-cycle
// sequences and random traffic against a period-position reference model.
module tb_clock_enable_scheduler;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_v = 1'b1;
  bit   run_v = 1'b0;
  bit   req_v = 1'b0;
  int   val_v = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  clock_enable_scheduler_if #(.CNT_W(CNT_W)) bus_if ();

  clock_enable_scheduler #(.CNT_W(CNT_W), .RESET_HP(2)) dut (
    .master_clock_i(clk),
    .reset_i       (rst_v),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: position within the current output period (0 .. 2*hp-1)
  int m_state, m_hp, m_pos, m_pend_hp;
  bit m_pend, m_ack, m_err;

  task automatic model_step(input bit r, input bit run, input bit req, input int val);
    int n_state, n_pos;
    bit bnd, apply, acc, rej;
    if (r) begin
      m_state = 0; m_hp = 2; m_pos = 0; m_pend = 0; m_pend_hp = 0; m_ack = 0; m_err = 0;
      return;
    end
    acc   = req && !m_pend && !m_ack && !m_err && (val != 0);
    rej   = req && !m_pend && !m_ack && !m_err && (val == 0);
    bnd   = (m_state != 0) && (m_pos == 2 * m_hp - 1);
    apply = m_pend && ((m_state == 0) || bnd);
    n_state = m_state;
    n_pos   = (m_pos + 1) % (2 * m_hp);
    if (m_state == 0) begin
      n_pos = 0;
      n_state = run ? 1 : 0;
    end else if (m_state == 1) begin
      if (!run && ((m_pos == 0) || bnd)) begin
        n_state = 0;
        n_pos = 0;
      end else if (!run) begin
        n_state = 2;
      end
    end else if (bnd) begin
      n_state = 0;
    end
    if (apply) begin
      m_hp = m_pend_hp;
      m_pend = 0;
    end
    if (acc) begin
      m_pend = 1;
      m_pend_hp = val;
    end
    m_ack = acc; m_err = rej; m_state = n_state; m_pos = n_pos;
  endtask

  // {state, busy, ack, err, clock_out, tick}
  function automatic logic [6:0] model_out();
    logic [1:0] st;
    logic c, t;
    st = m_state[1:0];
    c = (m_state != 0) && (m_pos >= m_hp);
    t = (m_state != 0) && (m_pos == m_hp);
    return {st, m_pend, m_ack, m_err, c, t};
  endfunction

  function automatic logic [6:0] dut_out();
    return {bus_if.state, bus_if.busy, bus_if.div_ack, bus_if.div_err, bus_if.clock_out, bus_if.tick};
  endfunction

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %b expected %b (state,busy,ack,err,clk,tick)", nm, $time, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    bus_if.run_enable = run_v;
    bus_if.div_req    = req_v;
    bus_if.div_value  = val_v[CNT_W-1:0];
    @(posedge clk);
    model_step(rst_v, run_v, req_v, val_v);
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic request(input int val, output int lat);
    req_v = 1'b1; val_v = val; lat = 0;
    do begin
      step();
      lat++;
    end while (!(bus_if.div_ack || bus_if.div_err) && lat < 64);
    req_v = 1'b0;
    check_int("req_timeout", int'(bus_if.div_ack || bus_if.div_err), 1);
  endtask

  task automatic phase_len(output int n);
    logic c;
    c = bus_if.clock_out;
    n = 1;
    step();
    while (bus_if.clock_out == c && n < 64) begin
      n++;
      step();
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1; req_v = 1'b0; run_v = 1'b0;
    step();
    rst_v = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         run;
    bit         req;
    int         val;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int lat, k, n, early, acc;
    bus_if.run_enable = 1'b0;
    bus_if.div_req    = 1'b0;
    bus_if.div_value  = '0;

    // Table: reset, divide-by-4, Div_Value = 0 rejection, boundary and immediate stops
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 7'b00_0_0_0_0_0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_0_0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_0_0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_1_1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_1_0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 0, 7'b01_0_0_1_0_0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 0, 7'b01_0_0_0_0_0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_1_1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_1_0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_0_0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_0_0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_1_1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_1_0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 0, 7'b00_0_0_0_0_0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 0, 7'b00_0_0_0_0_0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 0, 7'b01_0_0_0_0_0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 0, 7'b00_0_0_0_0_0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 0, 7'b00_0_0_0_0_0};

    for (int i = 0; i < 18; i++) begin
      rst_v = vecs[i].rst; run_v = vecs[i].run; req_v = vecs[i].req; val_v = vecs[i].val;
      step();
      check($sformatf("table%0d", i), dut_out(), vecs[i].exp);
    end

    // Divisor 5 accepted in RUN, applied at the next 1->0 boundary
    do_reset();
    run_v = 1'b1;
    repeat (5) step();
    request(5, lat);
    check_int("a_ack_latency", lat, 1);
    k = 0;
    while (bus_if.busy && k < 64) begin step(); k++; end
    check_int("a_busy_cycles", k, 3);
    check_int("a_clk_at_apply", int'(bus_if.clock_out), 0);
    phase_len(n);
    check_int("a_low_len", n, 5);
    phase_len(n);
    check_int("a_high_len", n, 5);

    // Stop one cycle into the high phase; reasserting run must not cancel it
    do_reset();
    run_v = 1'b1;
    k = 0;
    do begin step(); k++; end while (!bus_if.tick && k < 64);
    check_int("b_tick_seen", int'(bus_if.tick), 1);
    run_v = 1'b0;
    step();
    check_int("b_stopping", int'(bus_if.state), 2);
    check_int("b_high_held", int'(bus_if.clock_out), 1);
    run_v = 1'b1;
    step();
    check_int("b_idle_state", int'(bus_if.state), 0);
    check_int("b_idle_clk", int'(bus_if.clock_out), 0);
    run_v = 1'b0;
    acc = 0;
    repeat (4) begin step(); acc += int'(bus_if.tick) + int'(bus_if.clock_out); end
    check_int("b_quiet", acc, 0);

    // Second request held off while the first divisor is pending
    do_reset();
    run_v = 1'b1;
    repeat (3) step();
    request(3, lat);
    check_int("c_ack1_latency", lat, 1);
    req_v = 1'b1; val_v = 6; early = 0; k = 0;
    while (bus_if.busy && k < 64) begin
      step();
      k++;
      early += int'(bus_if.div_ack);
    end
    check_int("c_no_early_ack", early, 0);
    step();
    req_v = 1'b0;
    check_int("c_ack2", int'(bus_if.div_ack), 1);
    check_int("c_busy2", int'(bus_if.busy), 1);
    k = 0;
    while (bus_if.busy && k < 64) begin step(); k++; end
    phase_len(n);
    check_int("c_low_len", n, 6);
    phase_len(n);
    check_int("c_high_len", n, 6);

    // Reset in the high phase with a divisor pending, then restart at divide-by-4
    do_reset();
    run_v = 1'b1;
    repeat (3) step();
    request(5, lat);
    check("d_mid", {bus_if.clock_out, bus_if.busy, bus_if.div_ack, 4'b0000}, 7'b1110000);
    rst_v = 1'b1;
    step();
    check("d_reset_outs", dut_out(), 7'b0000000);
    rst_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check_int($sformatf("d_restart%0d", i),
                int'({bus_if.clock_out, bus_if.busy, bus_if.div_ack}),
                ((i % 4) >= 2) ? 4 : 0);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_v = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) run_v = !run_v;
      req_v = ($urandom_range(0, 3) == 0);
      val_v = $urandom_range(0, 4);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
